// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers running from one master clock.
// Each channel divides by 2*D, stages ratio updates until the end of a full output period,
// emits a one-cycle tick on every rising phase, and restarts in phase with sync_restart.
// Optional feature: define CLKGEN_GATE_EN to add a per-channel run_en freeze input.
module clock_divider_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sync_restart,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(NUM_CH):0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
`ifdef CLKGEN_GATE_EN
  input  logic [NUM_CH-1:0]       run_en,
`endif
  output logic [NUM_CH-1:0]       pending
);

  localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [DIV_W-1:0]  stage_q [NUM_CH];
  logic [DIV_W-1:0]  stage_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] wr_hit, wrap, hold;
  logic              in_range;
  logic              err_d, err_q;

  // Config decode: ready tracks the addressed channel's staging slot; out-of-range is always ready.
  always_comb begin
    cfg_ready = 1'b1;
    in_range  = 1'b0;
    wr_hit    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend_q[i];
        in_range  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    end
    err_d = cfg_valid & cfg_ready & ~in_range;
  end

  // Per-channel half-period boundary and stopped/frozen detection.
  always_comb begin
    wrap = '0;
    hold = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wrap[i] = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - DIV_W'(1));
`ifdef CLKGEN_GATE_EN
      // A disabled channel only freezes once it is in its low phase.
      hold[i] = (div_q[i] == '0) | (~run_en[i] & ~clk_q[i]);
`else
      hold[i] = (div_q[i] == '0);
`endif
    end
  end

  // Next-state for counters, output phase, active and staged ratios.
  always_comb begin
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    div_d   = div_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sync_restart) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
        // A write landing with the restart bypasses staging.
        if (wr_hit[i]) begin
          div_d[i] = cfg_div;
        end else if (pend_q[i]) begin
          div_d[i] = stage_q[i];
        end
      end else begin
        if (hold[i]) begin
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
          if (pend_q[i]) begin
            div_d[i]  = stage_q[i];
            pend_d[i] = 1'b0;
          end
        end else if (wrap[i]) begin
          cnt_d[i] = '0;
          clk_d[i] = ~clk_q[i];
          // Swap ratio only on the falling toggle so no runt pulse is produced.
          if (clk_q[i] && pend_q[i]) begin
            div_d[i]  = stage_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        if (wr_hit[i]) begin
          stage_d[i] = cfg_div;
          pend_d[i]  = 1'b1;
        end
      end
    end
    tick_d = clk_d & ~clk_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        stage_q[i] <= '0;
      end
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      stage_q <= stage_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;
  assign cfg_err = err_q;

endmodule
